// File: rtl/mem_loader.sv
// mem_loader: accepts a valid/ready stream of DATA_W-bit words and writes DEPTH
// of them into a 2^ADDR_W-word memory, starting at START_ADDR and wrapping.
// Done is raised once the last write strobe has been issued, and it releases
// the downstream accumulator.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN (running wrapping sum of the
// accepted words on Checksum). When the macro is undefined, Checksum is tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | after reset, waiting for Start
// S_LOAD  | accepting words, InReady high
// S_DRAIN | final write strobe on the memory port
// S_DONE  | image complete, Done high until Start or Reset
module mem_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int START_ADDR = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic              MemWriteEnable,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIN,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   WordCount,
  output logic [DATA_W-1:0] Checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int LAST_I = DEPTH - 1;
  localparam logic [ADDR_W:0]   LAST_CNT  = LAST_I[ADDR_W:0];
  localparam logic [ADDR_W-1:0] START_PTR = START_ADDR[ADDR_W-1:0];

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic              handshake;
  logic              last_word;
  logic              start_ok;

  assign InReady   = (state == S_LOAD);
  assign Busy      = (state == S_LOAD) || (state == S_DRAIN);
  assign Done      = (state == S_DONE);
  assign handshake = InValid && InReady;
  assign last_word = handshake && (WordCount == LAST_CNT);
  assign start_ok  = Start && ((state == S_IDLE) || (state == S_DONE));

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic. The word that completes the image moves the FSM to DRAIN,
  // so InReady drops on the following cycle and word DEPTH+1 is never accepted.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start) state_next = S_LOAD;
      S_LOAD:  if (last_word) state_next = S_DRAIN;
      S_DRAIN: state_next = S_DONE;
      S_DONE:  if (Start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered write port, write pointer and word counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      MemWriteEnable <= 1'b0;
      MemAddress     <= '0;
      MemDataIN      <= '0;
      ptr            <= '0;
      WordCount      <= '0;
    end else begin
      MemWriteEnable <= handshake;
      if (handshake) begin
        MemAddress <= ptr;
        MemDataIN  <= InData;
        ptr        <= ptr + 1'b1;
        WordCount  <= WordCount + 1'b1;
      end
      if (start_ok) begin
        ptr       <= START_PTR;
        WordCount <= '0;
      end
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  // Running wrapping sum of accepted words. It is frozen outside LOAD.
  always_ff @(posedge Clock) begin
    if (Reset)          sum <= '0;
    else if (start_ok)  sum <= '0;
    else if (handshake) sum <= sum + InData;
  end

  assign Checksum = sum;
`else
  assign Checksum = '0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: runs two mem_loader instances. Instance 0 uses the defaults
// (DEPTH 32, START_ADDR 0). Instance 1 uses DEPTH 4 and START_ADDR 30.
// A transaction-level model counts accepted words for each instance and
// derives every output from that count.
module tb_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic        start_v [2];
  logic        valid_v [2];
  logic [15:0] data_v  [2];

  logic        ready_o [2];
  logic        we_o    [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [4:0]  addr_o  [2];
  logic [15:0] mdata_o [2];
  logic [15:0] cs_o    [2];
  logic [5:0]  wc_o    [2];

  mem_loader u_dut0 (
    .Clock(clk), .Reset(rst_v[0]), .Start(start_v[0]), .InValid(valid_v[0]),
    .InData(data_v[0]), .InReady(ready_o[0]), .MemWriteEnable(we_o[0]),
    .MemAddress(addr_o[0]), .MemDataIN(mdata_o[0]), .Busy(busy_o[0]),
    .Done(done_o[0]), .WordCount(wc_o[0]), .Checksum(cs_o[0])
  );

  mem_loader #(.DEPTH(4), .START_ADDR(30)) u_dut1 (
    .Clock(clk), .Reset(rst_v[1]), .Start(start_v[1]), .InValid(valid_v[1]),
    .InData(data_v[1]), .InReady(ready_o[1]), .MemWriteEnable(we_o[1]),
    .MemAddress(addr_o[1]), .MemDataIN(mdata_o[1]), .Busy(busy_o[1]),
    .Done(done_o[1]), .WordCount(wc_o[1]), .Checksum(cs_o[1])
  );

  int depth_p [2] = '{32, 4};
  int start_p [2] = '{0, 30};

  // Model: a load is in progress, n words have been taken, and fc counts the
  // cycles since the image filled (1 = last strobe cycle, 2 = complete).
  bit m_in_load [2];
  int m_n       [2];
  int m_fc      [2];
  bit m_we      [2];
  bit m_hs      [2];
  int m_addr    [2];
  int m_data    [2];
  int m_sum     [2];

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_on = 0;

  int wa0[$], wd0[$], wa1[$], wd1[$];

  function automatic bit m_ready(int k);
    return m_in_load[k] && (m_n[k] < depth_p[k]);
  endfunction

  function automatic bit m_busy(int k);
    return m_in_load[k] && ((m_n[k] < depth_p[k]) || (m_fc[k] == 1));
  endfunction

  function automatic bit m_done(int k);
    return m_in_load[k] && (m_n[k] == depth_p[k]) && (m_fc[k] >= 2);
  endfunction

  function automatic int m_cs(int k);
`ifdef MEM_LOADER_CHECKSUM_EN
    return m_sum[k];
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, int k, longint act, longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d got 0x%0h want 0x%0h at %0t", name, k, act, exp, $time);
  endtask

  task automatic mdl_step(int k);
    bit hs;
    bit dn;
    if (rst_v[k]) begin
      m_in_load[k] = 0; m_n[k] = 0; m_fc[k] = 0; m_we[k] = 0; m_hs[k] = 0;
      m_addr[k] = 0; m_data[k] = 0; m_sum[k] = 0;
    end else begin
      hs = valid_v[k] && m_ready(k);
      dn = m_done(k);
      m_hs[k] = hs;
      m_we[k] = hs;
      if (hs) begin
        m_addr[k] = (start_p[k] + m_n[k]) % 32;
        m_data[k] = int'(data_v[k]);
        m_n[k]++;
        m_sum[k] = (m_sum[k] + int'(data_v[k])) % 65536;
        if (m_n[k] == depth_p[k]) m_fc[k] = 1;
      end else if (m_in_load[k] && m_n[k] == depth_p[k] && m_fc[k] == 1) begin
        m_fc[k] = 2;
      end
      if (start_v[k] && (!m_in_load[k] || dn)) begin
        m_in_load[k] = 1; m_n[k] = 0; m_fc[k] = 0; m_sum[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_step(0);
    mdl_step(1);
    @(negedge clk);
    #1;
  endtask

  // Compares every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("ready", k, ready_o[k], m_ready(k));
        chk("we",    k, we_o[k],    m_we[k]);
        chk("addr",  k, addr_o[k],  m_addr[k]);
        chk("mdata", k, mdata_o[k], m_data[k]);
        chk("busy",  k, busy_o[k],  m_busy(k));
        chk("done",  k, done_o[k],  m_done(k));
        chk("wc",    k, wc_o[k],    m_n[k]);
        chk("cs",    k, cs_o[k],    m_cs(k));
        chk("excl",  k, busy_o[k] && done_o[k], 0);
      end
      if (we_o[0] === 1'b1) begin wa0.push_back(int'(addr_o[0])); wd0.push_back(int'(mdata_o[0])); end
      if (we_o[1] === 1'b1) begin wa1.push_back(int'(addr_o[1])); wd1.push_back(int'(mdata_o[1])); end
    end
  end

  task automatic pulse_start(int k);
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
  endtask

  // mode: 0 continuous valid, 1 alternating, 2 random valid plus stray Start pulses.
  // kind: 0 idx+1, 1 0x0800, 2 random, 3 0xAAA0+idx.
  task automatic feed(int k, int nwords, int mode, int kind);
    int idx = 0;
    for (int c = 0; c < 2000 && idx < nwords; c++) begin
      case (mode)
        0:       valid_v[k] = 1'b1;
        1:       valid_v[k] = (c % 2 == 0);
        default: valid_v[k] = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) start_v[k] = ($urandom_range(0, 7) == 0);
      case (kind)
        0:       data_v[k] = 16'(idx + 1);
        1:       data_v[k] = 16'h0800;
        2:       data_v[k] = 16'($urandom);
        default: data_v[k] = 16'(32'hAAA0 + idx);
      endcase
      tick();
      if (m_hs[k]) idx++;
    end
    valid_v[k] = 1'b0;
    start_v[k] = 1'b0;
    chk("feed_count", k, idx, nwords);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; start_v[k] = 1'b0; valid_v[k] = 1'b0; data_v[k] = '0;
    end
    tick();
    chk_on = 1;
    tick();
    chk("rst_we", 0, we_o[0], 0);
    chk("rst_wc", 0, wc_o[0], 0);
    chk("rst_done", 0, done_o[0], 0);
    chk("rst_ready", 1, ready_o[1], 0);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    tick();

    // Continuous stream of 1..32.
    pulse_start(0);
    wa0.delete(); wd0.delete();
    feed(0, 32, 0, 0);
    chk("drain_done", 0, done_o[0], 0);
    chk("drain_busy", 0, busy_o[0], 1);
    chk("drain_addr", 0, addr_o[0], 31);
    tick();
    chk("t1_done", 0, done_o[0], 1);
    chk("t1_wc", 0, wc_o[0], 32);
    chk("t1_nwr", 0, wa0.size(), 32);
    chk("t1_a0", 0, wa0[0], 0);
    chk("t1_d0", 0, wd0[0], 1);
    chk("t1_a31", 0, wa0[31], 31);
    chk("t1_d31", 0, wd0[31], 32);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("t1_cs", 0, cs_o[0], 16'h0210);
`else
    chk("t1_cs", 0, cs_o[0], 0);
`endif
    tick();
    chk("t1_hold", 0, done_o[0], 1);

    // Restart from DONE, then alternate InValid.
    pulse_start(0);
    chk("restart_done", 0, done_o[0], 0);
    chk("restart_busy", 0, busy_o[0], 1);
    chk("restart_wc", 0, wc_o[0], 0);
    wa0.delete(); wd0.delete();
    feed(0, 32, 1, 0);
    tick(); tick();
    chk("t2_nwr", 0, wa0.size(), 32);
    chk("t2_a5", 0, wa0[5], 5);
    chk("t2_d5", 0, wd0[5], 6);

    // Random valid and random data, with Start pulsed during LOAD.
    pulse_start(0);
    feed(0, 32, 2, 2);
    tick(); tick();
    chk("t5_done", 0, done_o[0], 1);

    // Reset in the middle of a load, then reload from START_ADDR.
    pulse_start(0);
    feed(0, 10, 0, 0);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    chk("mid_we", 0, we_o[0], 0);
    chk("mid_addr", 0, addr_o[0], 0);
    chk("mid_data", 0, mdata_o[0], 0);
    chk("mid_wc", 0, wc_o[0], 0);
    chk("mid_busy", 0, busy_o[0], 0);
    chk("mid_ready", 0, ready_o[0], 0);
    tick();
    pulse_start(0);
    wa0.delete(); wd0.delete();
    feed(0, 3, 0, 0);
    tick();
    chk("reload_a0", 0, wa0[0], 0);
    chk("reload_wc", 0, wc_o[0], 3);

    // Wrapping addresses on the small instance, with InValid left high afterwards.
    pulse_start(1);
    wa1.delete(); wd1.delete();
    feed(1, 4, 0, 3);
    valid_v[1] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    valid_v[1] = 1'b0;
    chk("t3_nwr", 1, wa1.size(), 4);
    chk("t3_a0", 1, wa1[0], 30);
    chk("t3_a1", 1, wa1[1], 31);
    chk("t3_a2", 1, wa1[2], 0);
    chk("t3_a3", 1, wa1[3], 1);
    chk("t3_d3", 1, wd1[3], 16'hAAA3);
    chk("t3_ready", 1, ready_o[1], 0);
    chk("t3_wc", 1, wc_o[1], 4);

    for (int r = 0; r < 5; r++) begin
      pulse_start(1);
      feed(1, 4, 2, 2);
      tick(); tick();
    end

    // 32 words of 0x0800 wrap the sum back to zero.
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    pulse_start(0);
    feed(0, 32, 0, 1);
    tick(); tick();
    chk("t6_done", 0, done_o[0], 1);
    chk("t6_cs", 0, cs_o[0], 0);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
